// File: rtl/nested_expr_pkg.sv
// Shared types and constants for the nested expression sequencer.
// Holds the ALU opcode, operand-source and destination encodings, the
// microstep record, the fixed 19-step microprogram and the group layout
// helpers used by the step pointer.
package nested_expr_pkg;

    localparam int unsigned W      = 8;
    localparam int unsigned NSTEP  = 19;
    localparam int unsigned NGROUP = 4;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    typedef enum logic [2:0] {OpAdd, OpSub, OpMul, OpAnd, OpOr, OpXor, OpShl} op_e;

    typedef enum logic [2:0] {SrcA, SrcB, SrcC, SrcD, SrcE, SrcT0, SrcT1, SrcImm} src_e;

    typedef enum logic [2:0] {DstT0, DstT1, DstD1, DstD2, DstD3, DstD4} dst_e;

    typedef logic [4:0] step_t;
    typedef logic [1:0] grp_t;

    typedef struct packed {
        op_e          op;
        src_e         srca;
        src_e         srcb;
        logic [W-1:0] imm;
        dst_e         dst;
    } microstep_t;

    typedef struct packed {
        logic found;
        grp_t grp;
    } grp_sel_t;

    // Group layout: deep1 = steps 0..2, deep2 = 3..6, deep3 = 7..12, deep4 = 13..18.
    localparam microstep_t ROM [NSTEP] = '{
        // deep1
        '{OpAdd, SrcA,  SrcB,   8'h00, DstT0},
        '{OpMul, SrcT0, SrcC,   8'h00, DstT0},
        '{OpSub, SrcT0, SrcD,   8'h00, DstD1},
        // deep2
        '{OpAnd, SrcA,  SrcB,   8'h00, DstT1},
        '{OpOr,  SrcT1, SrcC,   8'h00, DstT1},
        '{OpXor, SrcT1, SrcD,   8'h00, DstT1},
        '{OpAdd, SrcT1, SrcE,   8'h00, DstD2},
        // deep3
        '{OpAdd, SrcA,  SrcB,   8'h00, DstT0},
        '{OpSub, SrcC,  SrcD,   8'h00, DstT1},
        '{OpMul, SrcT0, SrcT1,  8'h00, DstT0},
        '{OpAnd, SrcE,  SrcImm, 8'h0F, DstT1},
        '{OpShl, SrcT1, SrcImm, 8'h02, DstT1},
        '{OpAdd, SrcT0, SrcT1,  8'h00, DstD3},
        // deep4
        '{OpShl, SrcB,  SrcImm, 8'h01, DstT0},
        '{OpAdd, SrcA,  SrcT0,  8'h00, DstT0},
        '{OpAnd, SrcT0, SrcImm, 8'hFE, DstT0},
        '{OpSub, SrcC,  SrcD,   8'h00, DstT1},
        '{OpAnd, SrcT1, SrcImm, 8'h01, DstT1},
        '{OpOr,  SrcT0, SrcT1,  8'h00, DstD4}
    };

    function automatic step_t group_start(grp_t g);
        step_t s;
        unique case (g)
            2'd0: s = 5'd0;
            2'd1: s = 5'd3;
            2'd2: s = 5'd7;
            2'd3: s = 5'd13;
        endcase
        return s;
    endfunction

    function automatic step_t group_last(grp_t g);
        step_t s;
        unique case (g)
            2'd0: s = 5'd2;
            2'd1: s = 5'd6;
            2'd2: s = 5'd12;
            2'd3: s = 5'd18;
        endcase
        return s;
    endfunction

    // Lowest enabled group with index >= from; found=0 when none remain.
    // from is 3 bits so that "past the last group" (4) is representable.
    function automatic grp_sel_t first_enabled(logic [3:0] sel, logic [2:0] from);
        grp_sel_t r;
        r.found = 1'b0;
        r.grp   = '0;
        for (int g = NGROUP - 1; g >= 0; g--) begin
            if (sel[g] && (3'(g) >= from)) begin
                r.found = 1'b1;
                r.grp   = grp_t'(g);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_alu8.sv
// Purely combinational 8-bit ALU shared by every microstep.
// Ports:
//   op     - operation select
//   x, y   - operands
//   result - op(x, y), modulo 2^W (mul keeps the low W bits, shl zero-fills)
module shared_alu8
    import nested_expr_pkg::*;
(
    input  op_e          op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OpAdd:   result = x + y;
            OpSub:   result = x - y;
            OpMul:   result = x * y;
            OpAnd:   result = x & y;
            OpOr:    result = x | y;
            OpXor:   result = x ^ y;
            OpShl:   result = x << y;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/nested_expr_sequencer.sv
// Multi-cycle evaluator for deep1..deep4 using one shared ALU driven by a
// fixed microprogram, one microstep per cycle. Groups not selected by sel
// are skipped without spending cycles.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake (a..e, sel captured on accept)
//   a, b, c, d, e       - operands
//   sel                 - group enables: bit0 deep1 .. bit3 deep4
//   out_valid/out_ready - result handshake
//   deep1..deep4        - results, held stable while out_valid
//   busy                - high while executing or holding results
module nested_expr_sequencer
    import nested_expr_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] e,
    input  logic [3:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] deep1,
    output logic [W-1:0] deep2,
    output logic [W-1:0] deep3,
    output logic [W-1:0] deep4,
    output logic         busy
);

    state_e       state_q, state_d;
    step_t        ptr_q, ptr_d;
    grp_t         grp_q, grp_d;
    logic [3:0]   sel_q, sel_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;
    logic [W-1:0] t0_q, t0_d, t1_q, t1_d;
    logic [W-1:0] deep1_q, deep1_d, deep2_q, deep2_d;
    logic [W-1:0] deep3_q, deep3_d, deep4_q, deep4_d;

    microstep_t   ms;
    logic [W-1:0] srcval [8];
    logic [W-1:0] alu_x, alu_y, alu_res;
    grp_sel_t     nxt;

    assign ms = ROM[ptr_q];

    // Operand read ports indexed directly by the src_e encoding.
    always_comb begin
        srcval[SrcA]   = a_q;
        srcval[SrcB]   = b_q;
        srcval[SrcC]   = c_q;
        srcval[SrcD]   = d_q;
        srcval[SrcE]   = e_q;
        srcval[SrcT0]  = t0_q;
        srcval[SrcT1]  = t1_q;
        srcval[SrcImm] = ms.imm;
    end

    assign alu_x = srcval[ms.srca];
    assign alu_y = srcval[ms.srcb];

    shared_alu8 u_alu (
        .op     (ms.op),
        .x      (alu_x),
        .y      (alu_y),
        .result (alu_res)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grp_d   = grp_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        deep1_d = deep1_q;
        deep2_d = deep2_q;
        deep3_d = deep3_q;
        deep4_d = deep4_q;
        nxt     = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    d_d     = d;
                    e_d     = e;
                    sel_d   = sel;
                    deep1_d = '0;
                    deep2_d = '0;
                    deep3_d = '0;
                    deep4_d = '0;
                    nxt     = first_enabled(sel, 3'd0);
                    if (nxt.found) begin
                        ptr_d   = group_start(nxt.grp);
                        grp_d   = nxt.grp;
                        state_d = StExec;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StExec: begin
                case (ms.dst)
                    DstT0:   t0_d    = alu_res;
                    DstT1:   t1_d    = alu_res;
                    DstD1:   deep1_d = alu_res;
                    DstD2:   deep2_d = alu_res;
                    DstD3:   deep3_d = alu_res;
                    DstD4:   deep4_d = alu_res;
                    default: ;
                endcase
                if (ptr_q == group_last(grp_q)) begin
                    nxt = first_enabled(sel_q, {1'b0, grp_q} + 3'd1);
                    if (nxt.found) begin
                        ptr_d = group_start(nxt.grp);
                        grp_d = nxt.grp;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end

            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grp_q   <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            deep1_q <= '0;
            deep2_q <= '0;
            deep3_q <= '0;
            deep4_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grp_q   <= grp_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            deep1_q <= deep1_d;
            deep2_q <= deep2_d;
            deep3_q <= deep3_d;
            deep4_q <= deep4_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign deep1     = deep1_q;
    assign deep2     = deep2_q;
    assign deep3     = deep3_q;
    assign deep4     = deep4_q;

endmodule

// File: tb/tb_nested_expr_sequencer.sv
module tb_nested_expr_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b, c, d, e;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] deep1, deep2, deep3, deep4;
    logic       busy;

    int total;
    int bad;

    nested_expr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .deep1     (deep1),
        .deep2     (deep2),
        .deep3     (deep3),
        .deep4     (deep4),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish got=timeout want=finish");
        $fatal(1);
    end

    task automatic drive_ops(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                             input logic [7:0] id, input logic [7:0] ie, input logic [3:0] isel);
        a   = ia;
        b   = ib;
        c   = ic;
        d   = id;
        e   = ie;
        sel = isel;
    endtask

    // Presents one operand set in IDLE and lets it be accepted on the next edge.
    task automatic accept_txn(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                              input logic [7:0] id, input logic [7:0] ie, input logic [3:0] isel);
        @(negedge clk);
        drive_ops(ia, ib, ic, id, ie, isel);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat, output bit saw_ready);
        lat       = 0;
        saw_ready = 1'b0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (in_ready) saw_ready = 1'b1;
            if (out_valid) break;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_ops(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        total++;
        if ({out_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_valid_busy got=%b want=00", {out_valid, busy});
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h0) begin
            bad++;
            $display("FAIL reset_deep got=%h want=00000000", {deep1, deep2, deep3, deep4});
        end
        rst = 1'b0;
    endtask

    task automatic test_full;
        int lat;
        bit sr;
        out_ready = 1'b1;
        accept_txn(8'h03, 8'h05, 8'h02, 8'h04, 8'h13, 4'hF);
        wait_out(lat, sr);
        total++;
        if (lat !== 20) begin
            bad++;
            $display("FAIL full_latency got=%0d want=20", lat);
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h0C1AFC0C) begin
            bad++;
            $display("FAIL full_results got=%h want=0c1afc0c", {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL full_single_valid got=%b want=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_wrap;
        int lat;
        bit sr;
        out_ready = 1'b1;
        accept_txn(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 4'hF);
        wait_out(lat, sr);
        total++;
        if (lat !== 20) begin
            bad++;
            $display("FAIL wrap_latency got=%0d want=20", lat);
        end
        total++;
        if (sr !== 1'b0) begin
            bad++;
            $display("FAIL wrap_in_ready_low got=%b want=0", sr);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL wrap_busy_done got=%b want=1", busy);
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h02FE3EFD) begin
            bad++;
            $display("FAIL wrap_results got=%h want=02fe3efd", {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
    endtask

    task automatic test_partial;
        int lat;
        bit sr;
        out_ready = 1'b1;
        accept_txn(8'h03, 8'h05, 8'h02, 8'h04, 8'h13, 4'b0001);
        wait_out(lat, sr);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL deep1_only_latency got=%0d want=4", lat);
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h0C000000) begin
            bad++;
            $display("FAIL deep1_only_results got=%h want=0c000000",
                     {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
        accept_txn(8'h03, 8'h05, 8'h02, 8'h04, 8'h13, 4'b0000);
        wait_out(lat, sr);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL sel0_latency got=%0d want=1", lat);
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h0) begin
            bad++;
            $display("FAIL sel0_results got=%h want=00000000", {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat;
        bit sr;
        out_ready = 1'b0;
        accept_txn(8'h03, 8'h05, 8'h02, 8'h04, 8'h13, 4'hF);
        wait_out(lat, sr);
        total++;
        if (lat !== 20) begin
            bad++;
            $display("FAIL bp_latency got=%0d want=20", lat);
        end
        drive_ops(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 4'hF);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, deep1, deep2, deep3, deep4} !== {2'b10, 32'h0C1AFC0C}) begin
                bad++;
                $display("FAIL bp_hold_%0d got=%b_%b_%h want=1_0_0c1afc0c", i, out_valid,
                         in_ready, {deep1, deep2, deep3, deep4});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_release got=%b want=10", {in_ready, out_valid});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat, sr);
        total++;
        if (lat !== 20) begin
            bad++;
            $display("FAIL bp_next_latency got=%0d want=20", lat);
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h02FE3EFD) begin
            bad++;
            $display("FAIL bp_next_results got=%h want=02fe3efd", {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        bit sr;
        out_ready = 1'b1;
        accept_txn(8'h03, 8'h05, 8'h02, 8'h04, 8'h13, 4'hF);
        repeat (7) @(negedge clk);
        total++;
        if ({busy, deep1} !== {1'b1, 8'h0C}) begin
            bad++;
            $display("FAIL mid_before_reset got=%b_%h want=1_0c", busy, deep1);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL mid_reset_ctrl got=%b want=100", {in_ready, out_valid, busy});
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_deep got=%h want=00000000", {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
        rst = 1'b0;
        accept_txn(8'h03, 8'h05, 8'h02, 8'h04, 8'h13, 4'hF);
        wait_out(lat, sr);
        total++;
        if (lat !== 20) begin
            bad++;
            $display("FAIL post_reset_latency got=%0d want=20", lat);
        end
        total++;
        if ({deep1, deep2, deep3, deep4} !== 32'h0C1AFC0C) begin
            bad++;
            $display("FAIL post_reset_results got=%h want=0c1afc0c",
                     {deep1, deep2, deep3, deep4});
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_full();
        test_wrap();
        test_partial();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nested_expr_sequencer.md
Name: nested_expr_sequencer

Overview:
- Multi-cycle evaluator for the four nested 8-bit expressions deep1..deep4, built around one shared 8-bit ALU.
- The block schedules the ALU over a fixed microprogram, one ALU op per cycle.
- It replaces four parallel combinational trees with a time-multiplexed datapath.
- Operand capture and result delivery use valid/ready handshakes.

Parameters:
- W, 8, datapath width; all arithmetic is modulo 2^W.
- NSTEP, 19, total microprogram length (3+4+6+6).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a, b, c, d, e  input  W each  operands
- sel  input  4  result-group enable; bit0=deep1, bit1=deep2, bit2=deep3, bit3=deep4
- out_valid  output  1  results valid
- out_ready  input  1  consumer accepts results
- deep1, deep2, deep3, deep4  output  W each  results
- busy  output  1  high in EXEC or DONE

Behaviour:
- Reset values: FSM in IDLE; in_ready=1; out_valid=0; busy=0; deep1..4=0; scratch t0, t1 = 0; latched operands = 0.
- Reset asserted mid-operation aborts immediately to these values; no partial result is ever flagged valid.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - Accept happens on in_valid&&in_ready. On accept: latch a..e and sel, clear deep1..4 to 0, set step pointer to the first step of the lowest enabled group.
  - If sel==0, go to DONE. Otherwise go to EXEC.
- EXEC:
  - Exactly one microstep executes per cycle.
  - Each step reads two sources from {a..e latched, t0, t1, immediate}, applies one op, and writes t0, t1 or a deepN register at the clock edge.
  - After the last step of a group, the pointer jumps to the first step of the next enabled group. Disabled groups cost zero cycles.
  - After the last enabled step, go to DONE.
- DONE:
  - out_valid=1. deep1..4 are held stable.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready is 0 in EXEC and DONE, so in_valid is ignored there. in_ready rises the cycle after the output handshake.
- Latency: with N = sum of enabled group lengths (deep1=3, deep2=4, deep3=6, deep4=6), out_valid first asserts N+1 cycles after the accept cycle.
  - sel=0 gives 1 cycle.
  - sel=4'hF gives 20 cycles.
- Microprogram (fixed order):
  - deep1: t0=a+b; t0=t0*c; deep1=t0-d.
  - deep2: t1=a&b; t1=t1|c; t1=t1^d; deep2=t1+e.
  - deep3: t0=a+b; t1=c-d; t0=t0*t1; t1=e&8'h0F; t1=t1<<2; deep3=t0+t1.
  - deep4: t0=b<<1; t0=a+t0; t0=t0&8'hFE; t1=c-d; t1=t1&8'h01; deep4=t0|t1.
- Arithmetic rules:
  - Add, sub and mul wrap modulo 256; mul keeps the low 8 bits of the product.
  - Shift-left fills with 0 and drops overflow bits.
  - t0 and t1 are not assumed clear at group entry; every group initialises them before reading them.
- Disabled groups leave their deepN output at 0 for that transaction.
- Simultaneous events:
  - out_ready held high entering DONE: the handshake completes in the first DONE cycle, so out_valid is high for exactly 1 cycle.
  - in_valid held high continuously: back-to-back transactions are separated by one IDLE cycle.

Decomposition:
- Package nested_expr_pkg holds:
  - op enum {ADD, SUB, MUL, AND, OR, XOR, SHL}
  - source enum {A, B, C, D, E, T0, T1, IMM}
  - destination enum {T0, T1, D1, D2, D3, D4}
  - microstep struct (op, srcA, srcB, imm, dst)
  - the 19-entry microprogram ROM constant
  - group start/length constants
- Sub-module shared_alu8: purely combinational (op, x, y) -> result.
- The sequencer holds the FSM, step pointer, group-skip logic and register file.

Test Plan:
- a=3, b=5, c=2, d=4, e=8'h13, sel=F, out_ready=1 -> out_valid 20 cycles after accept; deep1=0x0C, deep2=0x1A, deep3=0xFC, deep4=0x0C.
- a=b=c=e=0xFF, d=0, sel=F -> deep1=0x02, deep2=0xFE (wrap checks); in_ready=0 for the whole transaction.
- sel=4'b0001 with the first scenario's operands -> out_valid 4 cycles after accept; deep1=0x0C, deep2..4=0. Then sel=0 -> out_valid 1 cycle after accept, all outputs 0.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs stable, out_valid held, no accept. Release out_ready -> in_ready=1 next cycle, new operands accepted.
- Assert rst at the 7th EXEC cycle of an sel=F run -> all outputs 0, in_ready=1 immediately. A fresh sel=F transaction after reset returns the correct values.
